// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory backend signals of the
// unified-memory arbiter into one interface.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Arbiter's view.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Pipeline stages plus memory backend view.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// data access; data wins unless fetch has been starved STARVE_MAX times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic [3:0]        starve_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              forced, grant_d, grant_i, done;

    assign forced = (starve_q == STARVE_LIM) && bus.if_req;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = 1'b0;
        grant_i      = 1'b0;
        done         = 1'b0;
        bus.if_valid = 1'b0;
        bus.d_valid  = 1'b0;
        bus.if_rdata = '0;
        bus.d_rdata  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !forced) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (bus.if_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    done         = 1'b1;
                    bus.if_valid = 1'b1;
                    bus.if_rdata = bus.mem_rdata;
                    state_d      = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    done        = 1'b1;
                    bus.d_valid = 1'b1;
                    bus.d_rdata = bus.mem_rdata;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; the async reset also kills an in-flight mem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_d) begin
            req_q   <= 1'b1;
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
        end else if (grant_i) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= bus.if_addr;
        end else if (done) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end
    end

    // Counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (grant_i || (state_q == IDLE && !bus.if_req)) begin
            starve_q <= '0;
        end else if (grant_d && starve_q != STARVE_LIM) begin
            starve_q <= starve_q + 4'd1;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_stall  = bus.if_req && !bus.if_valid;
    assign bus.d_stall   = bus.d_req && !bus.d_valid;
endmodule
